// File: rtl/mt_thread_scheduler.sv
// Fine-grained interleaved thread scheduler.
// Keeps one PC per hardware thread and presents one eligible thread per cycle,
// chosen round-robin, to the fetch stage over a valid/ready handshake.
//
// Ports:
//   clk            - clock, all state updates on the rising edge
//   rst            - asynchronous active-low reset
//   thread_enable  - per-thread enable mask
//   thread_stall   - per-thread stall mask
//   fetch_ready    - fetch accepts the presented issue
//   redirect_*     - PC redirect request for one thread
//   halt_*         - sticky halt request for one thread
//   issue_valid/issue_tid/issue_pc - registered issue slot toward fetch
//   all_halted     - registered flag, every thread halted
module mt_thread_scheduler #(
   parameter int unsigned         NUM_THREADS      = 4,
   parameter int unsigned         TID_WIDTH        = 2,
   parameter int unsigned         PC_WIDTH         = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC         = '0,
   parameter logic [PC_WIDTH-1:0] THREAD_PC_STRIDE = PC_WIDTH'(32'h100),
   parameter logic [PC_WIDTH-1:0] PC_INC           = PC_WIDTH'(4)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_THREADS-1:0] thread_enable,
   input  logic [NUM_THREADS-1:0] thread_stall,
   input  logic                   fetch_ready,
   input  logic                   redirect_valid,
   input  logic [TID_WIDTH-1:0]   redirect_tid,
   input  logic [PC_WIDTH-1:0]    redirect_pc,
   input  logic                   halt_valid,
   input  logic [TID_WIDTH-1:0]   halt_tid,
   output logic                   issue_valid,
   output logic [TID_WIDTH-1:0]   issue_tid,
   output logic [PC_WIDTH-1:0]    issue_pc,
   output logic                   all_halted
);

   logic [PC_WIDTH-1:0]    pc_q [NUM_THREADS];
   logic [PC_WIDTH-1:0]    pc_d [NUM_THREADS];
   logic [NUM_THREADS-1:0] halted_q, halted_d;
   logic [TID_WIDTH-1:0]   last_tid_q, last_tid_d;
   logic                   issue_valid_q, issue_valid_d;
   logic [TID_WIDTH-1:0]   issue_tid_q, issue_tid_d;
   logic [PC_WIDTH-1:0]    issue_pc_q, issue_pc_d;
   logic                   all_halted_q, all_halted_d;

   logic                   accept;
   logic                   squash;
   logic [NUM_THREADS-1:0] redir_hit;
   logic [NUM_THREADS-1:0] halt_hit;
   logic [NUM_THREADS-1:0] eligible;
   logic [TID_WIDTH-1:0]   pick;
   logic [PC_WIDTH-1:0]    pick_pc;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            pc_q[t] <= RESET_PC + PC_WIDTH'(t) * THREAD_PC_STRIDE;
         end
         halted_q      <= '0;
         last_tid_q    <= TID_WIDTH'(NUM_THREADS - 1);
         issue_valid_q <= 1'b0;
         issue_tid_q   <= '0;
         issue_pc_q    <= '0;
         all_halted_q  <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         halted_q      <= halted_d;
         last_tid_q    <= last_tid_d;
         issue_valid_q <= issue_valid_d;
         issue_tid_q   <= issue_tid_d;
         issue_pc_q    <= issue_pc_d;
         all_halted_q  <= all_halted_d;
      end
   end

   // Next state: PC/halt updates first, then selection sees the same-edge values
   always_comb begin
      accept        = issue_valid_q & fetch_ready;
      squash        = 1'b0;
      redir_hit     = '0;
      halt_hit      = '0;
      pc_d          = pc_q;
      halted_d      = halted_q;
      issue_valid_d = issue_valid_q;
      issue_tid_d   = issue_tid_q;
      issue_pc_d    = issue_pc_q;
      pick          = '0;
      pick_pc       = '0;

      // Out-of-range tids never match any thread, so they are dropped here.
      for (int t = 0; t < NUM_THREADS; t++) begin
         redir_hit[t] = redirect_valid && (redirect_tid == TID_WIDTH'(t));
         halt_hit[t]  = halt_valid && (halt_tid == TID_WIDTH'(t));
         if (accept && (issue_tid_q == TID_WIDTH'(t))) begin
            pc_d[t] = pc_q[t] + PC_INC;
         end
         // Redirect wins over the increment of a same-edge accept.
         if (redir_hit[t]) begin
            pc_d[t] = redirect_pc;
         end
         if (halt_hit[t]) begin
            halted_d[t] = 1'b1;
         end
         // A held issue whose thread is redirected or halted is withdrawn.
         if (issue_valid_q && !fetch_ready && (issue_tid_q == TID_WIDTH'(t)) &&
             (redir_hit[t] || halt_hit[t])) begin
            squash = 1'b1;
         end
      end

      last_tid_d = accept ? issue_tid_q : last_tid_q;
      eligible   = thread_enable & ~thread_stall & ~halted_d;

      // Round-robin: lowest eligible above last_tid, else lowest at/below it.
      for (int t = NUM_THREADS - 1; t >= 0; t--) begin
         if (eligible[t] && (TID_WIDTH'(t) <= last_tid_d)) begin
            pick = TID_WIDTH'(t);
         end
      end
      for (int t = NUM_THREADS - 1; t >= 0; t--) begin
         if (eligible[t] && (TID_WIDTH'(t) > last_tid_d)) begin
            pick = TID_WIDTH'(t);
         end
      end
      for (int t = 0; t < NUM_THREADS; t++) begin
         if (pick == TID_WIDTH'(t)) begin
            pick_pc = pc_d[t];
         end
      end

      if (squash) begin
         issue_valid_d = 1'b0;
      end else if (!issue_valid_q || fetch_ready) begin
         issue_valid_d = |eligible;
         issue_tid_d   = pick;
         issue_pc_d    = pick_pc;
      end

      all_halted_d = &halted_d;
   end

   assign issue_valid = issue_valid_q;
   assign issue_tid   = issue_tid_q;
   assign issue_pc    = issue_pc_q;
   assign all_halted  = all_halted_q;

endmodule
